imem_loader: RTL

- Write-side counterpart of the instruction memory. It takes a byte stream from a host link (for example, a UART receiver), packs the bytes into 32-bit instruction words, and writes them into the writable instruction memory at word-aligned byte addresses.
- It holds the processor in stall (busy) while loading.
- Loading ends on a terminator word or when the memory is full.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_assembler.sv | 54 +++++
 rtl/imem_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   state_t          : loader FSM states
//   IMEM_LAST_ADDR   : byte address of the final word slot (64 x 32-bit words)
//   IMEM_WORDS       : number of word slots in the instruction memory
//   WCNT_W           : width of a counter that can hold 0..IMEM_WORDS
//   DEFAULT_END_WORD : default terminator word that ends a load
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [7:0]  IMEM_LAST_ADDR   = 8'hFC;
    localparam int          IMEM_WORDS       = 64;
    localparam int          WCNT_W           = $clog2(IMEM_WORDS + 1);
    localparam logic [31:0] DEFAULT_END_WORD = 32'h11111111;

endpackage

// File: rtl/imem_loader_assembler.sv
// word_assembler
// Packs a stream of bytes into a 32-bit little-endian word: the k-th accepted
// byte lands in word[8k+7:8k]. Used by the loader for both instruction words
// and the trailing checksum.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   clear          : drop any partial word and restart at byte lane 0
//   byte_en        : a byte is transferred this cycle
//   byte_data      : the transferred byte
//   word           : lane contents including this cycle's byte, so the full
//                    word is available in the same cycle as word_complete
//   word_complete  : the 4th byte of a word is being transferred this cycle
module word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  idx_reg;
    logic [1:0]  idx_next;
    logic [31:0] lanes_reg;
    logic [31:0] lanes_next;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lanes_next[gi*8 +: 8] =
                clear                                  ? 8'h00     :
                (byte_en && (idx_reg == 2'(gi)))       ? byte_data :
                                                         lanes_reg[gi*8 +: 8];
        end
    endgenerate

    // The index wraps 3 -> 0 naturally, so no explicit restart is needed
    // between consecutive words.
    assign idx_next      = clear ? 2'd0 : (byte_en ? idx_reg + 2'd1 : idx_reg);
    assign word          = lanes_next;
    assign word_complete = byte_en && !clear && (idx_reg == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= 2'd0;
            lanes_reg <= 32'h0;
        end else begin
            idx_reg   <= idx_next;
            lanes_reg <= lanes_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Receives a byte stream from a host link, packs it into 32-bit words and
// writes them to the instruction memory at consecutive word-aligned byte
// addresses starting at BASE_ADDR. The processor is stalled (busy) while the
// load runs. The load ends after the terminator word has been written, or
// with err_full after the last word slot has been written.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: after the terminator word,
// four more bytes are collected as a checksum and compared against the XOR
// of every written word; err_csum flags a mismatch. Without the macro there
// is no checksum phase and err_csum is constant 0.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begins a load (honoured only when not busy)
//   byte_valid/data   : incoming byte stream
//   byte_ready        : loader accepts a byte this cycle
//   wr_en/addr/data   : instruction-memory write port, one strobe per word
//   busy              : processor stall while loading
//   done              : load finished, held until next start
//   err_full          : memory filled without a terminator
//   err_csum          : checksum mismatch
//   words_loaded      : number of words written (0..64)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [31:0]       END_WORD  = DEFAULT_END_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_full,
    output logic              err_csum,
    output logic [6:0]        words_loaded
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_LAST_ADDR);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [ADDR_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic [ADDR_W-1:0]   wr_addr_next;
    logic [31:0]         wr_data_reg;
    logic [31:0]         wr_data_next;
    logic [WCNT_W-1:0]   words_reg;
    logic [WCNT_W-1:0]   words_next;
    logic                done_reg;
    logic                done_next;
    logic                err_full_reg;
    logic                err_full_next;

    logic                asm_clear;
    logic                asm_byte_en;
    logic [31:0]         asm_word;
    logic                asm_complete;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         xor_reg;
    logic [31:0]         xor_next;
    logic                err_csum_reg;
    logic                err_csum_next;
`endif

    // Handshake-side outputs depend only on the registered state so the
    // byte transfer never loops back through the next-state logic.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_reg == COLLECT) || (state_reg == CHECK);
    assign busy       = (state_reg == COLLECT) || (state_reg == WRITE) ||
                        (state_reg == CHECK);
    assign err_csum   = err_csum_reg;
`else
    assign byte_ready = (state_reg == COLLECT);
    assign busy       = (state_reg == COLLECT) || (state_reg == WRITE);
    assign err_csum   = 1'b0;
`endif
    assign wr_en        = (state_reg == WRITE);
    assign wr_addr      = wr_addr_reg;
    assign wr_data      = wr_data_reg;
    assign done         = done_reg;
    assign err_full     = err_full_reg;
    assign words_loaded = words_reg;

    assign asm_byte_en  = byte_valid && byte_ready;

    word_assembler u_asm (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (asm_clear),
        .byte_en       (asm_byte_en),
        .byte_data     (byte_data),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;
        words_next    = words_reg;
        done_next     = done_reg;
        err_full_next = err_full_reg;
        asm_clear     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_next      = xor_reg;
        err_csum_next = err_csum_reg;
`endif

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = COLLECT;
                    addr_next     = BASE_ADDR;
                    words_next    = '0;
                    done_next     = 1'b0;
                    err_full_next = 1'b0;
                    asm_clear     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_next      = 32'h0;
                    err_csum_next = 1'b0;
`endif
                end
            end

            COLLECT: begin
                // Capture address and word on the 4th handshake so the write
                // port holds them through WRITE and keeps them afterwards.
                if (asm_complete) begin
                    state_next   = WRITE;
                    wr_addr_next = addr_reg;
                    wr_data_next = asm_word;
                end
            end

            WRITE: begin
                words_next = words_reg + WCNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_next   = xor_reg ^ wr_data_reg;
`endif
                if (wr_data_reg == END_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = DONE;
                    done_next  = 1'b1;
`endif
                end else if (addr_reg == LAST_ADDR) begin
                    // No wrap-around: a full memory without terminator ends
                    // the load with an error.
                    state_next    = DONE;
                    done_next     = 1'b1;
                    err_full_next = 1'b1;
                end else begin
                    state_next = COLLECT;
                    addr_next  = addr_reg + WORD_STEP;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                // xor_reg already includes the terminator word, which was
                // folded in during the preceding WRITE cycle.
                if (asm_complete) begin
                    state_next    = DONE;
                    done_next     = 1'b1;
                    err_csum_next = (asm_word != xor_reg);
                end
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            addr_reg     <= BASE_ADDR;
            wr_addr_reg  <= '0;
            wr_data_reg  <= 32'h0;
            words_reg    <= '0;
            done_reg     <= 1'b0;
            err_full_reg <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg      <= 32'h0;
            err_csum_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
            words_reg    <= words_next;
            done_reg     <= done_next;
            err_full_reg <= err_full_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_reg      <= xor_next;
            err_csum_reg <= err_csum_next;
`endif
        end
    end

endmodule
